// File: rtl/dma_timing_control.sv
// -----------------------------------------------------------------------------
// dma_timing_control
//   Transfer timing and control engine of an 8237A-style DMA controller.
//   Takes the channel granted by the priority encoder, runs the HRQ/HLDA bus
//   handshake, sequences the SI/S0/S1/S2/S3/SW/S4 transfer cycle, drives the
//   address and command strobes, counts words, detects terminal count and
//   hands the updated address/count back to the channel register file.
//
// Ports
//   Clock, Reset           system clock, synchronous active-high reset
//   ValidReqID, ReqID      granted channel from the priority encoder
//   PendingReq             live requests per channel (demand-mode continuation)
//   Hlda                   hold acknowledge from the CPU
//   Ready                  slow-device ready, low inserts SW wait states
//   EOPIn_n                external end-of-process, active low
//   Mode, CurAddr, CurCount, BaseAddr, BaseCount
//                          register-file view of the channel selected by ReqID
//   Hrq                    hold request to the CPU
//   AEN, ADSTB, Address    address-bus ownership, strobe and transfer address
//   MEMR_n, MEMW_n, IOR_n, IOW_n
//                          command strobes, active low
//   EOPOut_n, TC           terminal-count indications
//   WB, WBChannel, WBAddr, WBCount
//                          one-cycle write-back of the next address/count
//
// Every output is a flop loaded from the next-state decode, so each output
// shows the value belonging to the state the engine is currently in.
// -----------------------------------------------------------------------------
module dma_timing_control #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   ValidReqID,
  input  logic [1:0]             ReqID,
  input  logic [3:0]             PendingReq,
  input  logic                   Hlda,
  input  logic                   Ready,
  input  logic                   EOPIn_n,
  input  logic [7:0]             Mode,
  input  logic [ADDR_WIDTH-1:0]  CurAddr,
  input  logic [COUNT_WIDTH-1:0] CurCount,
  input  logic [ADDR_WIDTH-1:0]  BaseAddr,
  input  logic [COUNT_WIDTH-1:0] BaseCount,
  output logic                   Hrq,
  output logic                   AEN,
  output logic                   ADSTB,
  output logic [ADDR_WIDTH-1:0]  Address,
  output logic                   MEMR_n,
  output logic                   MEMW_n,
  output logic                   IOR_n,
  output logic                   IOW_n,
  output logic                   EOPOut_n,
  output logic                   WB,
  output logic [1:0]             WBChannel,
  output logic [ADDR_WIDTH-1:0]  WBAddr,
  output logic [COUNT_WIDTH-1:0] WBCount,
  output logic                   TC
);

  typedef enum logic [2:0] {
    ST_SI = 3'd0,
    ST_S0 = 3'd1,
    ST_S1 = 3'd2,
    ST_S2 = 3'd3,
    ST_S3 = 3'd4,
    ST_SW = 3'd5,
    ST_S4 = 3'd6
  } state_t;

  localparam logic [1:0] XFER_DEMAND = 2'b00;
  localparam logic [1:0] XFER_SINGLE = 2'b01;
  localparam logic [1:0] XFER_BLOCK  = 2'b10;
  localparam logic [1:0] XFER_CASC   = 2'b11;
  localparam logic [1:0] TYPE_WRITE  = 2'b01;
  localparam logic [1:0] TYPE_READ   = 2'b10;

  localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r;
  state_t                 next_state_s;

  // Active-channel context, frozen at the S0 -> S1 handover.
  // mode_r holds Mode[7:2]: [5:4] transfer mode, [3] decrement,
  // [2] autoinit, [1:0] transfer type.
  logic [1:0]             chan_r;
  logic [5:0]             mode_r;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic [ADDR_WIDTH-1:0]  base_addr_r;
  logic [COUNT_WIDTH-1:0] base_count_r;
  logic                   term_r;

  logic                   in_xfer_s;
  logic                   hlda_lost_s;
  logic                   eop_now_s;
  logic                   term_next_s;
  logic                   tc_now_s;
  logic                   enter_s4_s;
  logic                   latch_s;
  logic                   rd_phase_s;
  logic                   wr_phase_s;
  logic [ADDR_WIDTH-1:0]  addr_step_s;
  logic [ADDR_WIDTH-1:0]  wb_addr_s;
  logic [COUNT_WIDTH-1:0] wb_count_s;
  logic [ADDR_WIDTH-1:0]  addr_src_s;

  // Mode[1:0] is the channel-select field of the mode register; the channel
  // already arrives on ReqID, so those bits carry nothing for this block.
  logic                   unused_mode_s;
  assign unused_mode_s = ^Mode[1:0];

  // Transfer-cycle status: abort, external EOP and terminal-count detection.
  always_comb begin
    in_xfer_s   = (state_r == ST_S1) || (state_r == ST_S2) || (state_r == ST_S3) ||
                  (state_r == ST_SW) || (state_r == ST_S4);
    hlda_lost_s = in_xfer_s && !Hlda;
    // EOP is only honoured from S1 up to SW; S4 is already completing.
    eop_now_s   = ((state_r == ST_S1) || (state_r == ST_S2) || (state_r == ST_S3) ||
                   (state_r == ST_SW)) && !EOPIn_n;
    term_next_s = term_r || eop_now_s;
    // Count is checked before the decrement, so N programmed gives N+1 words.
    tc_now_s    = (count_r == COUNT_ZERO) || term_next_s;
    latch_s     = (state_r == ST_S0) && Hlda;
  end

  // Next-state decode of the transfer cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_SI: begin
        if (ValidReqID && !Hlda) next_state_s = ST_S0;
        else                     next_state_s = ST_SI;
      end
      ST_S0: begin
        if (Hlda) next_state_s = ST_S1;
        else      next_state_s = ST_S0;
      end
      ST_S1: begin
        if (hlda_lost_s) next_state_s = ST_SI;
        else             next_state_s = ST_S2;
      end
      ST_S2: begin
        if (hlda_lost_s) next_state_s = ST_SI;
        else             next_state_s = ST_S3;
      end
      ST_S3, ST_SW: begin
        if (hlda_lost_s) next_state_s = ST_SI;
        else if (Ready)  next_state_s = ST_S4;
        else             next_state_s = ST_SW;
      end
      ST_S4: begin
        if (hlda_lost_s || TC || term_r) begin
          next_state_s = ST_SI;
        end else begin
          case (mode_r[5:4])
            XFER_BLOCK:  next_state_s = ST_S1;
            XFER_DEMAND: begin
              if (PendingReq[chan_r]) next_state_s = ST_S1;
              else                    next_state_s = ST_SI;
            end
            XFER_SINGLE: next_state_s = ST_SI;
            XFER_CASC:   next_state_s = ST_SI;
            default:     next_state_s = ST_SI;
          endcase
        end
      end
      default: next_state_s = ST_SI;
    endcase
  end

  // Write-back values and strobe phases derived from the next state.
  always_comb begin
    enter_s4_s  = (next_state_s == ST_S4);
    rd_phase_s  = (next_state_s == ST_S2) || (next_state_s == ST_S3) || (next_state_s == ST_SW);
    wr_phase_s  = (next_state_s == ST_S3) || (next_state_s == ST_SW);
    addr_step_s = mode_r[3] ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
    if (tc_now_s && mode_r[2]) begin
      wb_addr_s  = base_addr_r;
      wb_count_s = base_count_r;
    end else begin
      wb_addr_s  = addr_step_s;
      wb_count_s = count_r - COUNT_ONE;
    end
    // Entering S1 from S0 the context is still being latched, so take the
    // address straight from the register file.
    if (state_r == ST_S0) addr_src_s = CurAddr;
    else                  addr_src_s = addr_r;
  end

  // State register and sticky external-terminate flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_SI;
      term_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s == ST_SI) term_r <= 1'b0;
      else                       term_r <= term_next_s;
    end
  end

  // Active-channel context: loaded at the handover, updated on entry to S4.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      chan_r       <= 2'd0;
      mode_r       <= 6'd0;
      addr_r       <= ADDR_ZERO;
      count_r      <= COUNT_ZERO;
      base_addr_r  <= ADDR_ZERO;
      base_count_r <= COUNT_ZERO;
    end else if (latch_s) begin
      chan_r       <= ReqID;
      mode_r       <= Mode[7:2];
      addr_r       <= CurAddr;
      count_r      <= CurCount;
      base_addr_r  <= BaseAddr;
      base_count_r <= BaseCount;
    end else if (enter_s4_s) begin
      addr_r       <= wb_addr_s;
      count_r      <= wb_count_s;
    end
  end

  // Bus handshake, address phase and command strobes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Hrq     <= 1'b0;
      AEN     <= 1'b0;
      ADSTB   <= 1'b0;
      Address <= ADDR_ZERO;
      MEMR_n  <= 1'b1;
      MEMW_n  <= 1'b1;
      IOR_n   <= 1'b1;
      IOW_n   <= 1'b1;
    end else begin
      Hrq     <= (next_state_s != ST_SI);
      AEN     <= (next_state_s != ST_SI) && (next_state_s != ST_S0);
      ADSTB   <= (next_state_s == ST_S1);
      if (next_state_s == ST_S1) Address <= addr_src_s;
      MEMR_n  <= !(rd_phase_s && (mode_r[1:0] == TYPE_READ));
      IOR_n   <= !(rd_phase_s && (mode_r[1:0] == TYPE_WRITE));
      MEMW_n  <= !(wr_phase_s && (mode_r[1:0] == TYPE_WRITE));
      IOW_n   <= !(wr_phase_s && (mode_r[1:0] == TYPE_READ));
    end
  end

  // Write-back strobe, terminal count and next address/count.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      WB        <= 1'b0;
      TC        <= 1'b0;
      EOPOut_n  <= 1'b1;
      WBChannel <= 2'd0;
      WBAddr    <= ADDR_ZERO;
      WBCount   <= COUNT_ZERO;
    end else begin
      WB       <= enter_s4_s;
      TC       <= enter_s4_s && tc_now_s;
      EOPOut_n <= !(enter_s4_s && tc_now_s);
      if (enter_s4_s) begin
        WBChannel <= chan_r;
        WBAddr    <= wb_addr_s;
        WBCount   <= wb_count_s;
      end
    end
  end

endmodule

// File: tb/tb_dma_timing_control.sv
module tb_dma_timing_control;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        ValidReqID = 1'b0;
  logic [1:0]  ReqID = 2'd0;
  logic [3:0]  PendingReq = 4'd0;
  logic        Hlda = 1'b0;
  logic        Ready = 1'b1;
  logic        EOPIn_n = 1'b1;
  logic [7:0]  Mode = 8'h00;
  logic [15:0] CurAddr = 16'h0000;
  logic [15:0] CurCount = 16'h0000;
  logic [15:0] BaseAddr = 16'h0000;
  logic [15:0] BaseCount = 16'h0000;
  logic        Hrq, AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n, EOPOut_n, WB, TC;
  logic [15:0] Address, WBAddr, WBCount;
  logic [1:0]  WBChannel;

  typedef struct packed {
    logic [1:0]  chan;
    logic [15:0] addr;
    logic [15:0] count;
    logic        tc;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int wb_seen = 0;

  always #5 Clock = ~Clock;

  dma_timing_control #(.ADDR_WIDTH(16), .COUNT_WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .ValidReqID(ValidReqID), .ReqID(ReqID),
    .PendingReq(PendingReq), .Hlda(Hlda), .Ready(Ready), .EOPIn_n(EOPIn_n),
    .Mode(Mode), .CurAddr(CurAddr), .CurCount(CurCount), .BaseAddr(BaseAddr),
    .BaseCount(BaseCount), .Hrq(Hrq), .AEN(AEN), .ADSTB(ADSTB), .Address(Address),
    .MEMR_n(MEMR_n), .MEMW_n(MEMW_n), .IOR_n(IOR_n), .IOW_n(IOW_n),
    .EOPOut_n(EOPOut_n), .WB(WB), .WBChannel(WBChannel), .WBAddr(WBAddr),
    .WBCount(WBCount), .TC(TC)
  );

  // Scoreboard: every write-back pulse is matched against the oldest expectation.
  always @(negedge Clock) begin : wb_monitor
    wb_exp_t e;
    if (WB === 1'b1) begin
      wb_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got ch=%0d addr=%h count=%h tc=%b, expected no write-back",
                 WBChannel, WBAddr, WBCount, TC);
      end else begin
        e = exp_q.pop_front();
        if ({WBChannel, WBAddr, WBCount, TC, EOPOut_n} !== {e.chan, e.addr, e.count, e.tc, ~e.tc}) begin
          miscompares++;
          $display("FAIL wb_record: got ch=%0d addr=%h count=%h tc=%b eop_n=%b, expected ch=%0d addr=%h count=%h tc=%b eop_n=%b",
                   WBChannel, WBAddr, WBCount, TC, EOPOut_n, e.chan, e.addr, e.count, e.tc, ~e.tc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] chan, input logic [15:0] addr,
                          input logic [15:0] count, input logic tc);
    wb_exp_t e;
    e.chan = chan; e.addr = addr; e.count = count; e.tc = tc;
    exp_q.push_back(e);
  endtask

  task automatic load_channel(input logic [1:0] id, input logic [7:0] mode,
                              input logic [15:0] addr, input logic [15:0] count,
                              input logic [15:0] baddr, input logic [15:0] bcount);
    ReqID = id; Mode = mode; CurAddr = addr; CurCount = count;
    BaseAddr = baddr; BaseCount = bcount;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    tick();
    vectors++;
    if ({Hrq, AEN, ADSTB, WB, TC} !== 5'b00000) begin
      miscompares++; $display("FAIL reset_ctrl: got %b, expected %b", {Hrq, AEN, ADSTB, WB, TC}, 5'b00000);
    end
    vectors++;
    if ({MEMR_n, MEMW_n, IOR_n, IOW_n, EOPOut_n} !== 5'b11111) begin
      miscompares++; $display("FAIL reset_strobes: got %b, expected %b", {MEMR_n, MEMW_n, IOR_n, IOW_n, EOPOut_n}, 5'b11111);
    end
    vectors++;
    if ({Address, WBAddr, WBCount, WBChannel} !== 50'd0) begin
      miscompares++; $display("FAIL reset_data: got %h, expected 0", {Address, WBAddr, WBCount, WBChannel});
    end
  endtask

  task automatic test_single_write();
    load_channel(2'd1, 8'h44, 16'h1000, 16'h0002, 16'h0000, 16'h0000);
    push_exp(2'd1, 16'h1000 + 16'h0001, 16'h0002 - 16'h0001, 1'b0);
    ValidReqID = 1'b1;
    tick();  // S0
    vectors++;
    if ({Hrq, AEN} !== 2'b10) begin
      miscompares++; $display("FAIL single_s0a: got hrq/aen %b, expected %b", {Hrq, AEN}, 2'b10);
    end
    tick();  // S0 again, Hlda still low
    vectors++;
    if ({Hrq, AEN} !== 2'b10) begin
      miscompares++; $display("FAIL single_s0b: got hrq/aen %b, expected %b", {Hrq, AEN}, 2'b10);
    end
    Hlda = 1'b1;
    tick();  // S1
    vectors++;
    if ({AEN, ADSTB, Address, MEMR_n, MEMW_n, IOR_n, IOW_n} !== {2'b11, 16'h1000, 4'b1111}) begin
      miscompares++; $display("FAIL single_s1: got aen/adstb/addr/strb %b/%h/%b, expected 11/1000/1111",
                              {AEN, ADSTB}, Address, {MEMR_n, MEMW_n, IOR_n, IOW_n});
    end
    tick();  // S2
    vectors++;
    if ({AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n} !== 6'b10_1101) begin
      miscompares++; $display("FAIL single_s2: got %b, expected %b", {AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n}, 6'b10_1101);
    end
    ValidReqID = 1'b0;
    tick();  // S3
    vectors++;
    if ({MEMR_n, MEMW_n, IOR_n, IOW_n} !== 4'b1001) begin
      miscompares++; $display("FAIL single_s3: got strobes %b, expected %b", {MEMR_n, MEMW_n, IOR_n, IOW_n}, 4'b1001);
    end
    tick();  // S4
    vectors++;
    if ({Hrq, WB, MEMR_n, MEMW_n, IOR_n, IOW_n} !== 6'b11_1111) begin
      miscompares++; $display("FAIL single_s4: got %b, expected %b", {Hrq, WB, MEMR_n, MEMW_n, IOR_n, IOW_n}, 6'b11_1111);
    end
    tick();  // SI
    vectors++;
    if ({Hrq, WB} !== 2'b00) begin
      miscompares++; $display("FAIL single_end: got hrq/wb %b, expected %b", {Hrq, WB}, 2'b00);
    end
    Hlda = 1'b0;
    tick();
  endtask

  task automatic test_block_read();
    load_channel(2'd2, 8'hA8, 16'h2000, 16'h0001, 16'h0000, 16'h0000);
    push_exp(2'd2, 16'h2000 - 16'h0001, 16'h0000, 1'b0);
    push_exp(2'd2, 16'h2000 - 16'h0002, 16'hFFFF, 1'b1);
    ValidReqID = 1'b1;
    tick();  // S0
    Hlda = 1'b1;
    tick();  // S1
    vectors++;
    if (Address !== 16'h2000) begin
      miscompares++; $display("FAIL block_addr0: got %h, expected %h", Address, 16'h2000);
    end
    tick();  // S2
    vectors++;
    if ({MEMR_n, MEMW_n, IOR_n, IOW_n} !== 4'b0111) begin
      miscompares++; $display("FAIL block_s2: got strobes %b, expected %b", {MEMR_n, MEMW_n, IOR_n, IOW_n}, 4'b0111);
    end
    tick();  // S3
    vectors++;
    if ({MEMR_n, MEMW_n, IOR_n, IOW_n} !== 4'b0110) begin
      miscompares++; $display("FAIL block_s3: got strobes %b, expected %b", {MEMR_n, MEMW_n, IOR_n, IOW_n}, 4'b0110);
    end
    tick();  // S4, first word
    tick();  // S1, second word
    vectors++;
    if ({ADSTB, Address} !== {1'b1, 16'h1FFF}) begin
      miscompares++; $display("FAIL block_addr1: got adstb/addr %b/%h, expected 1/1fff", ADSTB, Address);
    end
    ValidReqID = 1'b0;
    tick(); tick(); tick();  // S2, S3, S4
    vectors++;
    if ({WB, TC, EOPOut_n} !== 3'b110) begin
      miscompares++; $display("FAIL block_tc: got wb/tc/eop_n %b, expected %b", {WB, TC, EOPOut_n}, 3'b110);
    end
    tick();  // SI
    vectors++;
    if ({Hrq, AEN} !== 2'b00) begin
      miscompares++; $display("FAIL block_end: got hrq/aen %b, expected %b", {Hrq, AEN}, 2'b00);
    end
    Hlda = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    load_channel(2'd0, 8'h48, 16'h4000, 16'h0005, 16'h0000, 16'h0000);
    push_exp(2'd0, 16'h4001, 16'h0004, 1'b0);
    Ready = 1'b0;
    ValidReqID = 1'b1;
    tick();  // S0
    Hlda = 1'b1;
    tick(); tick(); tick();  // S1, S2, S3
    for (int i = 0; i < 3; i++) begin
      tick();  // SW
      vectors++;
      if ({WB, MEMR_n, MEMW_n, IOR_n, IOW_n} !== 5'b0_0110) begin
        miscompares++; $display("FAIL wait_sw%0d: got wb/strobes %b, expected %b", i, {WB, MEMR_n, MEMW_n, IOR_n, IOW_n}, 5'b0_0110);
      end
    end
    Ready = 1'b1;
    ValidReqID = 1'b0;
    tick();  // S4
    vectors++;
    if ({WB, MEMR_n, MEMW_n, IOR_n, IOW_n} !== 5'b1_1111) begin
      miscompares++; $display("FAIL wait_s4: got wb/strobes %b, expected %b", {WB, MEMR_n, MEMW_n, IOR_n, IOW_n}, 5'b1_1111);
    end
    tick();  // SI
    Hlda = 1'b0;
    tick();
  endtask

  task automatic test_autoinit();
    load_channel(2'd3, 8'h54, 16'h5000, 16'h0000, 16'h3000, 16'h0010);
    push_exp(2'd3, 16'h3000, 16'h0010, 1'b1);
    ValidReqID = 1'b1;
    tick();  // S0
    Hlda = 1'b1;
    tick(); tick(); tick();  // S1, S2, S3
    ValidReqID = 1'b0;
    tick();  // S4
    vectors++;
    if ({WB, TC, EOPOut_n} !== 3'b110) begin
      miscompares++; $display("FAIL autoinit_tc: got wb/tc/eop_n %b, expected %b", {WB, TC, EOPOut_n}, 3'b110);
    end
    tick();  // SI
    vectors++;
    if ({Hrq, TC, EOPOut_n} !== 3'b001) begin
      miscompares++; $display("FAIL autoinit_end: got hrq/tc/eop_n %b, expected %b", {Hrq, TC, EOPOut_n}, 3'b001);
    end
    Hlda = 1'b0;
    tick();
  endtask

  task automatic test_demand_eop();
    // Demand write, request kept alive, external EOP during the second word.
    load_channel(2'd1, 8'h04, 16'h6000, 16'h0005, 16'h0000, 16'h0000);
    push_exp(2'd1, 16'h6001, 16'h0004, 1'b0);
    push_exp(2'd1, 16'h6002, 16'h0003, 1'b1);
    PendingReq = 4'b0010;
    ValidReqID = 1'b1;
    tick();  // S0
    Hlda = 1'b1;
    tick(); tick(); tick(); tick();  // S1, S2, S3, S4
    tick();  // S1 again because the request is still pending
    vectors++;
    if ({ADSTB, Address} !== {1'b1, 16'h6001}) begin
      miscompares++; $display("FAIL demand_cont: got adstb/addr %b/%h, expected 1/6001", ADSTB, Address);
    end
    tick();  // S2
    EOPIn_n = 1'b0;
    tick();  // S3
    EOPIn_n = 1'b1;
    ValidReqID = 1'b0;
    tick();  // S4
    vectors++;
    if ({WB, TC, EOPOut_n} !== 3'b110) begin
      miscompares++; $display("FAIL demand_eop_tc: got wb/tc/eop_n %b, expected %b", {WB, TC, EOPOut_n}, 3'b110);
    end
    tick();  // SI despite PendingReq
    vectors++;
    if (Hrq !== 1'b0) begin
      miscompares++; $display("FAIL demand_eop_end: got hrq %b, expected %b", Hrq, 1'b0);
    end
    Hlda = 1'b0;
    tick();
    // Same again, but the request goes away during the first word.
    load_channel(2'd1, 8'h04, 16'h7000, 16'h0005, 16'h0000, 16'h0000);
    push_exp(2'd1, 16'h7001, 16'h0004, 1'b0);
    ValidReqID = 1'b1;
    tick();  // S0
    Hlda = 1'b1;
    tick(); tick(); tick();  // S1, S2, S3
    PendingReq = 4'b0000;
    ValidReqID = 1'b0;
    tick();  // S4
    vectors++;
    if ({WB, TC} !== 2'b10) begin
      miscompares++; $display("FAIL demand_drop_s4: got wb/tc %b, expected %b", {WB, TC}, 2'b10);
    end
    tick();  // SI
    vectors++;
    if ({Hrq, AEN} !== 2'b00) begin
      miscompares++; $display("FAIL demand_drop_end: got hrq/aen %b, expected %b", {Hrq, AEN}, 2'b00);
    end
    Hlda = 1'b0;
    tick();
  endtask

  task automatic test_aborts();
    int wb_before;
    // Hold acknowledge withdrawn in S3.
    wb_before = wb_seen;
    load_channel(2'd1, 8'h44, 16'h8000, 16'h0003, 16'h0000, 16'h0000);
    ValidReqID = 1'b1;
    tick();  // S0
    Hlda = 1'b1;
    tick(); tick(); tick();  // S1, S2, S3
    vectors++;
    if ({MEMR_n, MEMW_n, IOR_n, IOW_n} !== 4'b1001) begin
      miscompares++; $display("FAIL abort_s3: got strobes %b, expected %b", {MEMR_n, MEMW_n, IOR_n, IOW_n}, 4'b1001);
    end
    Hlda = 1'b0;
    ValidReqID = 1'b0;
    tick();  // SI
    vectors++;
    if ({Hrq, AEN, WB, MEMR_n, MEMW_n, IOR_n, IOW_n} !== 7'b000_1111) begin
      miscompares++; $display("FAIL abort_hlda: got %b, expected %b", {Hrq, AEN, WB, MEMR_n, MEMW_n, IOR_n, IOW_n}, 7'b000_1111);
    end
    tick(); tick();
    vectors++;
    if (wb_seen !== wb_before) begin
      miscompares++; $display("FAIL abort_hlda_wb: got %0d write-backs, expected %0d", wb_seen, wb_before);
    end
    // Reset while waiting in SW.
    wb_before = wb_seen;
    load_channel(2'd2, 8'h48, 16'h9000, 16'h0007, 16'h0000, 16'h0000);
    Ready = 1'b0;
    ValidReqID = 1'b1;
    tick();  // S0
    Hlda = 1'b1;
    tick(); tick(); tick(); tick();  // S1, S2, S3, SW
    vectors++;
    if ({MEMR_n, MEMW_n, IOR_n, IOW_n} !== 4'b0110) begin
      miscompares++; $display("FAIL reset_sw_pre: got strobes %b, expected %b", {MEMR_n, MEMW_n, IOR_n, IOW_n}, 4'b0110);
    end
    Reset = 1'b1;
    tick();
    vectors++;
    if ({Hrq, AEN, ADSTB, WB, TC, MEMR_n, MEMW_n, IOR_n, IOW_n, EOPOut_n} !== 10'b00000_11111) begin
      miscompares++; $display("FAIL reset_sw_ctrl: got %b, expected %b",
                              {Hrq, AEN, ADSTB, WB, TC, MEMR_n, MEMW_n, IOR_n, IOW_n, EOPOut_n}, 10'b00000_11111);
    end
    vectors++;
    if ({Address, WBAddr, WBCount, WBChannel} !== 50'd0) begin
      miscompares++; $display("FAIL reset_sw_data: got %h, expected 0", {Address, WBAddr, WBCount, WBChannel});
    end
    Reset = 1'b0;
    Hlda = 1'b0;
    ValidReqID = 1'b0;
    Ready = 1'b1;
    tick(); tick();
    vectors++;
    if ({wb_seen != wb_before, Hrq} !== 2'b00) begin
      miscompares++; $display("FAIL reset_sw_after: got wb_seen=%0d hrq=%b, expected wb_seen=%0d hrq=0", wb_seen, Hrq, wb_before);
    end
  endtask

  task automatic test_hlda_busy();
    // CPU already holds the bus for itself: no hold request may be raised.
    load_channel(2'd0, 8'h44, 16'hA000, 16'h0001, 16'h0000, 16'h0000);
    Hlda = 1'b1;
    ValidReqID = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if ({Hrq, AEN} !== 2'b00) begin
      miscompares++; $display("FAIL hlda_busy: got hrq/aen %b, expected %b", {Hrq, AEN}, 2'b00);
    end
    Hlda = 1'b0;
    ValidReqID = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_block_read();
    test_wait_states();
    test_autoinit();
    test_demand_eop();
    test_aborts();
    test_hlda_busy();
    tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL wb_missing: got %0d write-backs still outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_timing_control.md
Name: dma_timing_control

Overview:
- Transfer timing and control engine for the 8237A-style DMA controller; sits directly downstream of the channel priority encoder.
- Consumes the granted channel ID, its valid flag and the pending-request vector, and owns the HRQ/HLDA bus handshake.
- Runs the SI/S0/S1/S2/S3/SW/S4 transfer cycle, drives the address and the memory/IO command strobes, counts words and detects terminal count.
- Writes updated address/count back to the channel register file.

Parameters:
ADDR_WIDTH, 16, width of address and base/current address values
COUNT_WIDTH, 16, width of word-count values

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
ValidReqID  in  1  encoder has a granted channel
ReqID  in  2  granted channel number
PendingReq  in  4  currently valid (sensed, unmasked) requests per channel
Hlda  in  1  hold acknowledge from CPU
Ready  in  1  slow-device ready; low inserts wait states
EOPIn_n  in  1  external end-of-process, active low
Mode  in  8  mode register of the channel selected by ReqID: [7:6] xfer mode, [5] decrement, [4] autoinit, [3:2] type
CurAddr  in  ADDR_WIDTH  current address of the channel selected by ReqID
CurCount  in  COUNT_WIDTH  current count of the channel selected by ReqID
BaseAddr  in  ADDR_WIDTH  base address of the channel selected by ReqID, used for autoinit
BaseCount  in  COUNT_WIDTH  base count of the channel selected by ReqID, used for autoinit
Hrq  out  1  hold request to CPU
AEN  out  1  address enable, DMA owns the address bus
ADSTB  out  1  address strobe
Address  out  ADDR_WIDTH  transfer address
MEMR_n, MEMW_n, IOR_n, IOW_n  out  1 each  command strobes, active low
EOPOut_n  out  1  terminal-count indication, active low
WB  out  1  one-cycle write-back strobe
WBChannel  out  2  channel being written back
WBAddr  out  ADDR_WIDTH  next address to write back
WBCount  out  COUNT_WIDTH  next count to write back
TC  out  1  terminal-count flag to the status register, pulses with WB

Behaviour:
- All outputs are registered or decoded from the state only.
- Reset values: state = SI; Hrq, AEN, ADSTB, WB, TC = 0; all four strobes and EOPOut_n = 1; Address, WBAddr, WBCount, WBChannel = 0.
- Reset asserted mid-transfer returns all outputs to their reset values on the next edge. No write-back occurs.
- SI: when ValidReqID & ~Hlda, go to S0.
- S0: Hrq = 1. When Hlda is sampled 1:
  - latch ReqID, Mode, CurAddr, CurCount, BaseAddr, BaseCount into the active-channel registers;
  - go to S1.
- Hrq is held at 1 in states S0 through S4. It drops on the edge that enters SI.
- S1: AEN = 1, ADSTB = 1, Address = active address register. Next state is S2.
- S2: AEN = 1. The read strobe asserts:
  - type 01 (write): IOR_n = 0;
  - type 10 (read): MEMR_n = 0;
  - type 00 (verify) or 11: no strobes.
- S3: the read strobe is held and the write strobe asserts (MEMW_n for write, IOW_n for read).
  - Ready = 1: next state is S4.
  - Ready = 0: next state is SW.
- SW: strobes are held as in S3. The block stays in SW while Ready = 0 and goes to S4 when Ready = 1.
- S4: all strobes deassert. WB = 1 for this cycle only.
  - WBAddr = address ±1 (−1 if Mode[5] = 1), wrapping modulo 2^ADDR_WIDTH.
  - WBCount = count − 1, wrapping modulo 2^COUNT_WIDTH.
  - The internal registers take the same values.
- Terminal count: TC = 1 in S4 when the count was 0 before the decrement, so N+1 transfers are made for a programmed count of N. EOPOut_n = 0 in the same cycle.
- Autoinit: if TC and Mode[4] = 1, WBAddr and WBCount carry BaseAddr and BaseCount instead of the decremented values.
- External EOP: EOPIn_n is sampled in S1..SW. If it is low, a sticky terminate flag is set. The current transfer completes through S4, with WB = 1 and TC = 1, and the block ends.
- Exit from S4:
  - terminate flag or TC set: go to SI;
  - single (01): go to SI;
  - block (10): go to S1;
  - demand (00): go to S1 if PendingReq[active channel] = 1, else SI;
  - cascade (11): treated as single.
- Hlda sampled 0 in any of S1..S4 or SW aborts the transfer:
  - go to SI;
  - all strobes deassert on that edge;
  - no WB is issued unless the current state is S4.
- ReqID and ValidReqID changes after S0 are ignored until the block returns to SI.
- SI with Hlda already 1: stay in SI (the CPU holds the bus with no DMA).

Test Plan:
1. Single write: ReqID = 1, Mode = 0x44, CurAddr = 0x1000, CurCount = 0x0002, Hlda raised 2 cycles after Hrq -> states S0,S0,S1,S2,S3,S4. IOR_n low in S2–S3, MEMW_n low in S3. WB with WBAddr = 0x1001, WBCount = 0x0001, TC = 0. Hrq drops.
2. Block read, decrement: Mode = 0xA8, CurAddr = 0x2000, CurCount = 0x0001 -> two transfers, Address 0x2000 then 0x1FFF. Second S4 gives TC = 1, EOPOut_n = 0, WBCount = 0xFFFF. Then SI.
3. Wait states: Ready held low 3 cycles during S3 -> 3 SW cycles with MEMR_n/IOW_n held low. S4 follows one cycle after Ready rises.
4. Autoinit: Mode = 0x54, CurCount = 0x0000, BaseAddr = 0x3000, BaseCount = 0x0010 -> TC = 1, WBAddr = 0x3000, WBCount = 0x0010.
5. Demand and EOP: demand mode with PendingReq held high. Pulse EOPIn_n low during the second transfer's S2 -> that transfer completes with TC = 1 and the block returns to SI. Repeat with PendingReq dropped instead -> SI after the current S4 with TC = 0.
6. Aborts: Hlda dropped in S3 -> SI next edge, strobes high, no WB. Separately, Reset asserted in SW -> all outputs at their reset values next edge.
